relu_maxpool_13x13: RTL and testbench
=====================================

# relu_maxpool_13x13

Streaming ReLU plus 3x3 stride-2 max-pool stage that sits directly downstream of the 13x13 single-channel convolution stage. It consumes the 13x13 conv result as a raster-ordered pixel stream and produces the 6x6 pooled map as a raster-ordered stream. Both sides use valid/ready handshakes. Only per-column partial maxima are stored; no full-frame buffer.

## Interface
- `IN_H`, default 13: input rows; odd, ≥3.
- `IN_W`, default 13: input columns; odd, ≥3.
- `DATA_W`, default 16: pixel width, signed two's complement.
- `OUT_H`/`OUT_W`: localparams, (IN_H-3)/2+1 and (IN_W-3)/2+1 (6 and 6 at defaults).
- `clk  in  1`: single clock; everything is on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `clear  in  1`: synchronous frame abort, same effect as reset.
- `in_valid  in  1`: input pixel valid.
- `in_ready  out  1`: stage can accept a pixel.
- `in_data  in  DATA_W`: conv output pixel, raster order, row 0 col 0 first.
- `out_valid  out  1`: pooled pixel valid.
- `out_ready  in  1`: downstream accepts.
- `out_data  out  DATA_W`: pooled pixel, raster order.
- `out_last  out  1`: high with the final (OUT_H*OUT_W-th) pooled pixel of a frame.

## Operation
- A beat is accepted when `in_valid && in_ready`. Counters `row` (0..IN_H-1) and `col` (0..IN_W-1) advance on each accepted beat. Both wrap to 0 after (IN_H-1, IN_W-1), and the next beat starts a new frame.
- Pre-processing: `x = relu(in_data)` when enabled (see Configuration), else `x = in_data`.
- Horizontal window register `hacc`, updated per accepted beat:
  - col 0: `hacc = x`.
  - odd col: `hacc = max(hacc, x)`.
  - even col ≥2: the window closes. `hw = max(hacc, x)` for window k = col/2-1, then `hacc = x`.
- Vertical accumulator `vacc[0:OUT_W-1]`, updated for window k whenever a horizontal window closes:
  - row 0: `vacc[k] = hw`.
  - odd row: `vacc[k] = max(vacc[k], hw)`.
  - even row ≥2: emit `max(vacc[k], hw)` as output (row/2-1, k), then `vacc[k] = hw`.
- Row 2b is shared between pool bands b-1 and b; this is the required overlap for stride 2.
- All comparisons are signed and there is no width growth; the output is one of the input values.
- Output register: one pixel is held. `in_ready = !out_valid || out_ready`. An emitting beat loads the register. Because each input beat produces at most one output, no further buffering is needed.
- `out_last` is set when the emitted output is at (OUT_H-1, OUT_W-1).

## Timing
- Latency: `out_valid` rises the cycle after the accepted input beat that completes the window (input (2,2) → output (0,0)).
- Throughput: one input per cycle when `out_ready` is held high.
- `out_valid`/`out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- Simultaneous output drain and new emitting beat in the same cycle: the register reloads and `out_valid` stays 1.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `in_ready=1`, `row=col=0`, `hacc=0`, `vacc=0`.
- Reset or `clear` mid-frame discards the partial frame and any held output. The next accepted beat is treated as (0,0).
- `clear` takes priority over a same-cycle handshake; that beat is dropped.

## Configuration
- `RELU_MAXPOOL_RELU_EN` defined: negative inputs are clamped to 0 before pooling, so outputs are ≥0.
- Undefined: pure signed max-pool, and negative outputs are possible.

## Structure
- Shared package `cnn_pkg` holds:
  - `pixel_t` (signed logic [DATA_W-1:0]).
  - `smax` signed-max function.
  - `relu` function.
  - Default 13x13 dimension constants.
- One sub-module, `pool_raster_ctr`: row/col counters with the window-close and band-emit strobes.

## Test plan
- Ramp frame `in = row*13+col`, `out_ready=1` → 36 outputs `(2i+2)*13+2j+2`; first is 28, last is 168 with `out_last=1`; no stall cycles.
- Single hot pixel 100 at (2,2), rest 0 → outputs (0,0),(0,1),(1,0),(1,1) are 100, all others 0.
- All inputs -16 → with the macro defined all outputs are 0; with it undefined all outputs are -16.
- Ramp frame with `out_ready` toggling 1,0,0,1 → `in_ready` drops whenever the held output is not drained; outputs stay stable while stalled; output sequence is identical to the no-stall case.
- Assert `rst_n=0` after 40 beats, then send a full ramp frame → exactly 36 correct outputs, none carried over from the aborted frame.
- Two back-to-back ramp frames with a `clear` pulse between them → second frame's outputs match the first; `out_last` is asserted exactly once per frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types, default dimensions and signed helper functions.
package cnn_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned IMG_H  = 13;
  localparam int unsigned IMG_W  = 13;
  // Wide working width so the helpers serve any pixel width up to 64 bits.
  localparam int unsigned WIDE_W = 64;

  typedef logic signed [PIX_W-1:0]  pixel_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Signed maximum of two sign-extended pixels.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  // Clamp negative values to zero.
  function automatic wide_t relu(input wide_t a);
    return a[WIDE_W-1] ? '0 : a;
  endfunction

endpackage

// File: rtl/pool_raster_ctr.sv
// Raster row/col counters for the 3x3 stride-2 pool, plus window strobes
// decoded from the current (pre-advance) position.
module pool_raster_ctr
  import cnn_pkg::*;
#(
  parameter int unsigned IN_H  = IMG_H,
  parameter int unsigned IN_W  = IMG_W,
  parameter int unsigned ROW_W = $clog2(IN_H),
  parameter int unsigned COL_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             adv,
  output logic             col_first_c,
  output logic             hclose_c,
  output logic             row_first_c,
  output logic             vemit_c,
  output logic [COL_W-1:0] win_idx_c,
  output logic [ROW_W-1:0] band_idx_c
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Next position: advance on accepted beat, wrap at frame end, clear wins.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (adv) begin
      if (col_q == COL_W'(IN_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IN_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Even column/row >= 2 closes a horizontal window / completes a pool band.
  assign col_first_c = (col_q == '0);
  assign hclose_c    = !col_q[0] && (col_q != '0);
  assign row_first_c = (row_q == '0);
  assign vemit_c     = !row_q[0] && (row_q != '0);
  assign win_idx_c   = (col_q >> 1) - COL_W'(1);
  assign band_idx_c  = (row_q >> 1) - ROW_W'(1);

endmodule

// File: rtl/relu_maxpool_13x13.sv
// Streaming ReLU + 3x3 stride-2 max-pool over a raster 13x13 frame.
// Keeps one horizontal partial max and one vertical partial max per output
// column; a single output register drives the downstream handshake.
// Optional feature: define RELU_MAXPOOL_RELU_EN to clamp negative inputs to 0.
module relu_maxpool_13x13
  import cnn_pkg::*;
#(
  parameter int unsigned IN_H   = IMG_H,
  parameter int unsigned IN_W   = IMG_W,
  parameter int unsigned DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned OUT_H = (IN_H - 3) / 2 + 1;
  localparam int unsigned OUT_W = (IN_W - 3) / 2 + 1;
  localparam int unsigned ROW_W = $clog2(IN_H);
  localparam int unsigned COL_W = $clog2(IN_W);

  logic                     accept;
  logic                     col_first_c, hclose_c, row_first_c, vemit_c;
  logic [COL_W-1:0]         win_idx_c;
  logic [ROW_W-1:0]         band_idx_c;

  logic signed [DATA_W-1:0] in_s;
  wide_t                    x_w;
  logic signed [DATA_W-1:0] x, hw, vsel, vmax;

  logic signed [DATA_W-1:0] hacc_q, hacc_d;
  logic signed [DATA_W-1:0] vacc_q [OUT_W];
  logic signed [DATA_W-1:0] vacc_d [OUT_W];
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_s     = in_data;

  pool_raster_ctr #(
    .IN_H (IN_H),
    .IN_W (IN_W),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .adv        (accept),
    .col_first_c(col_first_c),
    .hclose_c   (hclose_c),
    .row_first_c(row_first_c),
    .vemit_c    (vemit_c),
    .win_idx_c  (win_idx_c),
    .band_idx_c (band_idx_c)
  );

  // Pixel pre-processing and window maxima for the current beat.
  always_comb begin
`ifdef RELU_MAXPOOL_RELU_EN
    x_w = relu(wide_t'(in_s));
`else
    x_w = wide_t'(in_s);
`endif
    x    = DATA_W'(x_w);
    hw   = DATA_W'(smax(wide_t'(hacc_q), x_w));
    vsel = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (win_idx_c == COL_W'(k)) vsel = vacc_q[k];
    end
    vmax = DATA_W'(smax(wide_t'(vsel), wide_t'(hw)));
  end

  // Accumulator and output-register next state; clear overrides everything.
  always_comb begin
    hacc_d      = hacc_q;
    vacc_d      = vacc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (col_first_c || hclose_c) hacc_d = x;
      else                         hacc_d = hw;

      if (hclose_c) begin
        for (int k = 0; k < OUT_W; k++) begin
          if (win_idx_c == COL_W'(k)) begin
            if (row_first_c || vemit_c) vacc_d[k] = hw;
            else                        vacc_d[k] = vmax;
          end
        end
        if (vemit_c) begin
          out_valid_d = 1'b1;
          out_data_d  = vmax;
          out_last_d  = (band_idx_c == ROW_W'(OUT_H - 1)) &&
                        (win_idx_c == COL_W'(OUT_W - 1));
        end
      end
    end

    if (clear) begin
      hacc_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      for (int k = 0; k < OUT_W; k++) vacc_d[k] = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < OUT_W; k++) vacc_q[k] <= '0;
    end else begin
      hacc_q      <= hacc_d;
      vacc_q      <= vacc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_relu_maxpool_13x13.sv
// Scoreboard bench for relu_maxpool_13x13: expected pooled pixels are queued
// as the completing input beat is accepted and popped as outputs are taken.
module tb_relu_maxpool_13x13;

  localparam int H  = 13;
  localparam int W  = 13;
  localparam int OH = 6;
  localparam int OW = 6;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, out_data;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          out_cnt, last_cnt, stall_cycles, phase;
  logic [15:0] first_out;
  logic        chk_rdy = 1'b0;
  logic        held_v = 1'b0;
  logic [15:0] held_d;
  logic        held_l;
  logic signed [15:0] frame [H][W];

  always #5 clk = ~clk;

  relu_maxpool_13x13 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  function automatic logic signed [15:0] act(input logic signed [15:0] v);
`ifdef RELU_MAXPOOL_RELU_EN
    return (v < 0) ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Direct 3x3 window max over the stored frame.
  function automatic logic signed [15:0] ref_pool(input int i, input int j);
    logic signed [15:0] m;
    m = act(frame[2*i][2*j]);
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (act(frame[2*i+dr][2*j+dc]) > m) m = act(frame[2*i+dr][2*j+dc]);
    return m;
  endfunction

  // Output monitor: scoreboard compare plus stall-stability checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (chk_rdy) begin
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          errors++;
          $display("FAIL in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%0d l=%b want no output", out_data, out_last);
        end else begin
          e = sbq.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL out_data: got d=%0d l=%b want d=%0d l=%b",
                     $signed(out_data), out_last, $signed(e.data), e.last);
          end
        end
        if (out_cnt == 0) first_out = out_data;
        out_cnt++;
        if (out_last) last_cnt++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end
  end

  function automatic logic ready_pat(input bit stall, input int ph);
    return stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       frame[r][c] = 16'(r * 13 + c);
          1:       frame[r][c] = (r == 2 && c == 2) ? 16'sd100 : 16'sd0;
          2:       frame[r][c] = -16'sd16;
          default: frame[r][c] = 16'($urandom_range(0, 65535));
        endcase
  endtask

  // Drive nbeats of the frame in raster order; optionally drain afterwards.
  task automatic drive_frame(input int kind, input bit stall, input int nbeats, input bit drain);
    bit acc;
    int guard, r, c;
    fill(kind);
    out_cnt = 0; last_cnt = 0; stall_cycles = 0; phase = 0;
    for (int b = 0; b < nbeats; b++) begin
      r = b / W; c = b % W;
      in_valid = 1'b1;
      in_data  = frame[r][c];
      acc = 1'b0; guard = 0;
      while (!acc) begin
        out_ready = ready_pat(stall, phase);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc && r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0)
          sbq.push_back('{ref_pool(r/2-1, c/2-1), (r == H-1 && c == W-1)});
        if (!acc) stall_cycles++;
        @(posedge clk); #1;
        phase++;
        guard++;
        if (!acc && guard > 20) begin
          checks++; errors++;
          $display("FAIL accept_timeout: got in_ready=%b want 1 within 20 cycles", in_ready);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    if (drain) begin
      for (int i = 0; i < 200 && (sbq.size() != 0 || out_valid); i++) begin
        out_ready = ready_pat(stall, phase);
        @(posedge clk); #1;
        phase++;
      end
      out_ready = 1'b1;
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
    end
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (out_cnt != OH * OW) begin
      errors++;
      $display("FAIL %s_count: got %0d want %0d", name, out_cnt, OH * OW);
    end
    checks++;
    if (last_cnt != 1) begin
      errors++;
      $display("FAIL %s_last: got %0d want 1", name, last_cnt);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%b d=%0d l=%b rdy=%b want v=0 d=0 l=0 rdy=1",
               name, out_valid, out_data, out_last, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    drive_frame(0, 1'b0, H * W, 1'b1);
    check_counts("ramp");
    checks++;
    if (first_out !== 16'd28) begin
      errors++;
      $display("FAIL ramp_first: got %0d want 28", first_out);
    end
    checks++;
    if (stall_cycles != 0) begin
      errors++;
      $display("FAIL ramp_throughput: got %0d stall cycles want 0", stall_cycles);
    end
  endtask

  task automatic test_hot_pixel();
    drive_frame(1, 1'b0, H * W, 1'b1);
    check_counts("hot");
  endtask

  task automatic test_negative();
    drive_frame(2, 1'b0, H * W, 1'b1);
    check_counts("neg");
  endtask

  task automatic test_stall();
    chk_rdy = 1'b1;
    drive_frame(0, 1'b1, H * W, 1'b1);
    chk_rdy = 1'b0;
    check_counts("stall");
    checks++;
    if (stall_cycles == 0) begin
      errors++;
      $display("FAIL stall_backpressure: got 0 stall cycles want >0");
    end
  endtask

  task automatic test_random_stall();
    drive_frame(3, 1'b1, H * W, 1'b1);
    check_counts("rand");
  endtask

  task automatic test_reset_mid();
    drive_frame(0, 1'b0, 40, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    check_idle("reset_mid_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_frame(0, 1'b0, H * W, 1'b1);
    check_counts("after_reset");
  endtask

  task automatic test_back_to_back();
    drive_frame(0, 1'b0, H * W, 1'b1);
    check_counts("b2b_first");
    // Clear with a concurrent valid beat: the beat must be dropped.
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h7fff;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check_idle("clear_state");
    drive_frame(0, 1'b0, H * W, 1'b1);
    check_counts("b2b_second");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hot_pixel();
    test_negative();
    test_stall();
    test_random_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
